// File: rtl/mcu_spi_target.sv
// SPI target between the board MCU and the FPGA control targets: oversamples mode-0 SPI in the
// clk domain, routes each frame's bytes to one of the targets and shifts their replies out on MISO.
module mcu_spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_TARGETS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   spi_io_ss,
    input  logic                   spi_io_clk,
    input  logic                   spi_io_din,
    output logic                   spi_io_dout,
    output logic                   mcu_start,
    output logic [7:0]             mcu_dout,
    output logic [NUM_TARGETS-1:0] mcu_strobe,
    input  logic [7:0]             mcu_sys_din,
    input  logic [7:0]             mcu_hid_din,
    input  logic [7:0]             mcu_osd_din,
    input  logic [7:0]             mcu_sdc_din
);

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   ss_prev_q;
    logic                   sck_prev_q;
    logic                   ss_s;
    logic                   sck_s;
    logic                   din_s;
    logic                   ss_rise;
    logic                   ss_fall;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   frame_active;

    logic                   armed_q;
    logic [2:0]             bit_cnt_q;
    logic [1:0]             byte_idx_q;
    logic [7:0]             rx_q;
    logic [7:0]             tx_q;
    logic [7:0]             target_q;
    logic                   tgt_valid_q;
    logic                   byte_done_q;
    logic                   load_a_q;
    logic                   load_b_q;
    logic                   load_zero_q;

    logic [7:0]             resp_mux;
    logic [NUM_TARGETS-1:0] strobe_sel;
    logic                   rx_target_ok;

    assign ss_s         = ss_sync_q[SYNC_STAGES-1];
    assign sck_s        = sck_sync_q[SYNC_STAGES-1];
    assign din_s        = din_sync_q[SYNC_STAGES-1];
    assign ss_rise      = ss_s & ~ss_prev_q;
    assign ss_fall      = ~ss_s & ss_prev_q;
    assign sck_rise     = sck_s & ~sck_prev_q;
    assign sck_fall     = ~sck_s & sck_prev_q;
    assign frame_active = armed_q & ~ss_s;
    assign rx_target_ok = ({24'd0, rx_q} < NUM_TARGETS);
    assign spi_io_dout  = tx_q[7];

    always_comb begin
        resp_mux = 8'h00;
        case (target_q)
            8'd0:    resp_mux = mcu_sys_din;
            8'd1:    resp_mux = mcu_hid_din;
            8'd2:    resp_mux = mcu_osd_din;
            8'd3:    resp_mux = mcu_sdc_din;
            default: resp_mux = 8'h00;
        endcase
    end

    always_comb begin
        strobe_sel = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            strobe_sel[i] = ({24'd0, target_q} == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ss_sync_q   <= '0;
            sck_sync_q  <= '0;
            din_sync_q  <= '0;
            ss_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            target_q    <= 8'h00;
            tgt_valid_q <= 1'b0;
            byte_done_q <= 1'b0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            load_zero_q <= 1'b0;
            mcu_strobe  <= '0;
            mcu_start   <= 1'b0;
            mcu_dout    <= 8'h00;
        end else begin
            ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_io_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
            ss_prev_q  <= ss_s;
            sck_prev_q <= sck_s;
            if (ss_s) begin
                armed_q <= 1'b1;
            end

            byte_done_q <= 1'b0;
            load_a_q    <= 1'b0;
            load_b_q    <= load_a_q;
            mcu_strobe  <= '0;
            mcu_start   <= 1'b0;

            if (ss_rise) begin
                // Frame end wins over a same-cycle completion; partial bits are dropped.
                bit_cnt_q  <= 3'd0;
                byte_idx_q <= 2'd0;
                load_b_q   <= 1'b0;
            end else if (ss_fall && armed_q) begin
                bit_cnt_q   <= 3'd0;
                byte_idx_q  <= 2'd0;
                tx_q        <= 8'h00;
                tgt_valid_q <= 1'b0;
                load_b_q    <= 1'b0;
            end else if (frame_active) begin
                if (sck_rise) begin
                    rx_q        <= {rx_q[6:0], din_s};
                    bit_cnt_q   <= bit_cnt_q + 3'd1;
                    byte_done_q <= (bit_cnt_q == 3'd7);
                end
                // The fall after a byte's last bit must not shift out the freshly loaded MSB.
                if (sck_fall && bit_cnt_q != 3'd0) begin
                    tx_q <= {tx_q[6:0], 1'b0};
                end
                if (byte_done_q) begin
                    mcu_dout <= rx_q;
                    load_a_q <= 1'b1;
                    if (byte_idx_q == 2'd0) begin
                        target_q    <= rx_q;
                        tgt_valid_q <= rx_target_ok;
                        load_zero_q <= 1'b1;
                    end else begin
                        if (tgt_valid_q) begin
                            mcu_strobe <= strobe_sel;
                            mcu_start  <= (byte_idx_q == 2'd1);
                        end
                        load_zero_q <= ~tgt_valid_q;
                    end
                    if (byte_idx_q != 2'd2) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                // Targets register their reply on the strobe cycle; pick it up one cycle later.
                if (load_b_q) begin
                    tx_q <= load_zero_q ? 8'h00 : resp_mux;
                end
            end
        end
    end

endmodule
